// File: rtl/shift_pkg.sv
// Shared definitions for the shift issue path: shift type codes,
// the sequencer state encoding and the default datapath widths.
package shift_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned AMT_W_DEF  = 5;

  localparam logic [1:0] SHIFT_SLL = 2'b00;
  localparam logic [1:0] SHIFT_SRL = 2'b01;
  localparam logic [1:0] SHIFT_SRA = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ISSUE   = 2'b01,
    CAPTURE = 2'b10,
    HOLD    = 2'b11
  } state_t;

endpackage

// File: rtl/SHIFTER.sv
// KGP_miniRISC shifter: registered barrel shift, updated only while enabled.
// Type 2'b11 passes the operand through unchanged.
module SHIFTER
  import shift_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned AMT_W  = AMT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] a,
  input  logic [1:0]        ShiftTypeSHIFTER,
  input  logic [AMT_W-1:0]  ShiftAmntSHIFTER,
  input  logic              ShifterEnblSHIFTER,
  output logic [DATA_W-1:0] SHIFTERout
);

  logic [DATA_W-1:0] shifted;

  // Combinational shift selected by type code.
  always_comb begin
    shifted = a;
    case (ShiftTypeSHIFTER)
      SHIFT_SLL: shifted = a << ShiftAmntSHIFTER;
      SHIFT_SRL: shifted = a >> ShiftAmntSHIFTER;
      SHIFT_SRA: shifted = $signed(a) >>> ShiftAmntSHIFTER;
      default:   shifted = a;
    endcase
  end

  // Output register, loaded while the enable is high.
  always_ff @(posedge clk) begin
    if (!rst) begin
      SHIFTERout <= '0;
    end else if (ShifterEnblSHIFTER) begin
      SHIFTERout <= shifted;
    end
  end

endmodule

// File: rtl/shift_issue_unit.sv
// Execute-stage sequencer in front of SHIFTER: accepts one shift op,
// drives SHIFTER for two cycles, captures its result and holds it for
// writeback until drained.
// Optional: define SHIFT_ZERO_FLAG_EN to add the out_zero result flag.
module shift_issue_unit
  import shift_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned AMT_W  = AMT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_operand,
  input  logic [1:0]        in_type,
  input  logic              in_use_reg_amt,
  input  logic [AMT_W-1:0]  in_shamt,
  input  logic [DATA_W-1:0] in_reg_amt,
  input  logic [4:0]        in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [4:0]        out_rd
`ifdef SHIFT_ZERO_FLAG_EN
  ,
  output logic              out_zero
`endif
);

  state_t            state;
  state_t            state_next;
  logic [DATA_W-1:0] operand_q;
  logic [1:0]        type_q;
  logic [AMT_W-1:0]  amt_q;
  logic [4:0]        rd_q;
  logic [AMT_W-1:0]  amt_sel;
  logic              accept;
  logic              shifter_en;
  logic [DATA_W-1:0] shifter_out;
  logic              unused_amt_hi;

  // Only the low AMT_W bits of a register amount matter.
  assign amt_sel       = in_use_reg_amt ? in_reg_amt[AMT_W-1:0] : in_shamt;
  assign unused_amt_hi = ^in_reg_amt[DATA_W-1:AMT_W];

  // Next-state and handshake/enable decode.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    shifter_en = 1'b0;
    case (state)
      IDLE: begin
        in_ready = rst;
        if (in_valid) state_next = ISSUE;
      end
      ISSUE: begin
        shifter_en = 1'b1;
        state_next = CAPTURE;
      end
      CAPTURE: begin
        shifter_en = 1'b1;
        state_next = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept = (state == IDLE) && in_valid;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Op latch on accept; SHIFTER inputs stay put until the next accept.
  always_ff @(posedge clk) begin
    if (!rst) begin
      operand_q <= '0;
      type_q    <= '0;
      amt_q     <= '0;
      rd_q      <= '0;
    end else if (accept) begin
      operand_q <= in_operand;
      type_q    <= in_type;
      amt_q     <= amt_sel;
      rd_q      <= in_rd;
    end
  end

  // Result capture at the end of CAPTURE; held through HOLD.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_result <= '0;
      out_rd     <= '0;
    end else if (state == CAPTURE) begin
      out_result <= shifter_out;
      out_rd     <= rd_q;
    end
  end

`ifdef SHIFT_ZERO_FLAG_EN
  // Zero flag captured alongside the result.
  always_ff @(posedge clk) begin
    if (!rst)                   out_zero <= 1'b0;
    else if (state == CAPTURE)  out_zero <= (shifter_out == '0);
  end
`endif

  SHIFTER #(
    .DATA_W (DATA_W),
    .AMT_W  (AMT_W)
  ) u_shifter (
    .clk                (clk),
    .rst                (rst),
    .a                  (operand_q),
    .ShiftTypeSHIFTER   (type_q),
    .ShiftAmntSHIFTER   (amt_q),
    .ShifterEnblSHIFTER (shifter_en),
    .SHIFTERout         (shifter_out)
  );

endmodule

// File: tb/tb_shift_issue_unit.sv
// Scoreboard bench for shift_issue_unit: stimulus pushes hand-computed
// results, a negedge monitor pops and compares on each output handshake.
module tb_shift_issue_unit;
  import shift_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  typedef struct {
    logic [DW-1:0] result;
    logic [4:0]    rd;
    logic          zero;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_operand;
  logic [1:0]    in_type;
  logic          in_use_reg_amt;
  logic [AW-1:0] in_shamt;
  logic [DW-1:0] in_reg_amt;
  logic [4:0]    in_rd;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_result;
  logic [4:0]    out_rd;
`ifdef SHIFT_ZERO_FLAG_EN
  logic          out_zero;
`endif

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  shift_issue_unit #(.DATA_W(DW), .AMT_W(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_operand     (in_operand),
    .in_type        (in_type),
    .in_use_reg_amt (in_use_reg_amt),
    .in_shamt       (in_shamt),
    .in_reg_amt     (in_reg_amt),
    .in_rd          (in_rd),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_result     (out_result),
    .out_rd         (out_rd)
`ifdef SHIFT_ZERO_FLAG_EN
    ,
    .out_zero       (out_zero)
`endif
  );

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compare every completed output handshake against the queue.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      exp_t e;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual=%h required=none at %0t", out_result, $time);
      end else begin
        e = exp_q.pop_front();
        check("out_result", out_result, e.result);
        check("out_rd", DW'(out_rd), DW'(e.rd));
`ifdef SHIFT_ZERO_FLAG_EN
        check("out_zero", DW'(out_zero), DW'(e.zero));
`endif
      end
    end
  end

  // Drive one op, wait for acceptance, then verify the two-edge latency.
  task automatic send(input logic [DW-1:0] op, input logic [1:0] typ, input logic use_reg,
                      input logic [AW-1:0] sh, input logic [DW-1:0] ra, input logic [4:0] rd,
                      input logic [DW-1:0] exp_res, input logic exp_zero);
    int cnt = 0;
    exp_t e;
    in_operand     = op;
    in_type        = typ;
    in_use_reg_amt = use_reg;
    in_shamt       = sh;
    in_reg_amt     = ra;
    in_rd          = rd;
    in_valid       = 1'b1;
    while (!in_ready && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=in_ready_low required=in_ready_high at %0t", $time);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    e.result = exp_res;
    e.rd     = rd;
    e.zero   = exp_zero;
    exp_q.push_back(e);
    #1 in_valid = 1'b0;
    check("lat_edge_n", DW'(out_valid), DW'(0));
    @(posedge clk); #1;
    check("lat_edge_n1", DW'(out_valid), DW'(0));
    @(posedge clk); #1;
    check("lat_edge_n2", DW'(out_valid), DW'(1));
  endtask

  task automatic drain();
    int cnt = 0;
    while (exp_q.size() != 0 && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d required=0 pending at %0t", exp_q.size(), $time);
      exp_q.delete();
    end
  endtask

  initial begin
    logic [DW-1:0] held;
    rst = 1'b0; in_valid = 1'b0; in_operand = '0; in_type = '0;
    in_use_reg_amt = 1'b0; in_shamt = '0; in_reg_amt = '0; in_rd = '0;
    out_ready = 1'b1;

    // Reset
    @(posedge clk); @(posedge clk); #1;
    check("rst_out_valid", DW'(out_valid), DW'(0));
    check("rst_out_result", out_result, '0);
    check("rst_in_ready", DW'(in_ready), DW'(0));
    rst = 1'b1;
    #1;
    check("idle_in_ready", DW'(in_ready), DW'(1));
    @(posedge clk); #1;
    check("idle_out_valid", DW'(out_valid), DW'(0));

    // Directed ops with out_ready high
    send(32'd11, SHIFT_SLL, 1'b0, 5'd2, 32'd0, 5'd5, 32'd44, 1'b0);
    drain();
    send(32'h8000_0010, SHIFT_SRA, 1'b1, 5'd9, 32'd36, 5'd7, 32'hF800_0001, 1'b0);
    drain();
    send(32'h7000_0000, SHIFT_SRA, 1'b0, 5'd8, 32'd0, 5'd1, 32'h0070_0000, 1'b0);
    drain();
    send(32'h8000_0000, SHIFT_SRL, 1'b0, 5'd31, 32'd0, 5'd31, 32'h0000_0001, 1'b0);
    drain();

    // Back-pressure, with a second op waiting upstream
    out_ready = 1'b0;
    send(32'h0000_00F0, SHIFT_SRL, 1'b0, 5'd4, 32'd0, 5'd3, 32'h0000_000F, 1'b0);
    in_operand = 32'd3; in_type = SHIFT_SLL; in_use_reg_amt = 1'b1;
    in_shamt = 5'd7; in_reg_amt = 32'd33; in_rd = 5'd9; in_valid = 1'b1;
    held = out_result;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid", DW'(out_valid), DW'(1));
      check("bp_in_ready", DW'(in_ready), DW'(0));
      check("bp_out_result", out_result, 32'h0000_000F);
      check("bp_out_rd", DW'(out_rd), DW'(3));
      check("bp_stable", out_result, held);
    end
    out_ready = 1'b1;
    send(32'd3, SHIFT_SLL, 1'b1, 5'd7, 32'd33, 5'd9, 32'd6, 1'b0);
    drain();

    // Zero-flag patterns (results checked in every build)
    send(32'h1, SHIFT_SRL, 1'b0, 5'd1, 32'd0, 5'd12, 32'h0, 1'b1);
    drain();
    send(32'h1, SHIFT_SLL, 1'b0, 5'd0, 32'd0, 5'd13, 32'h1, 1'b0);
    drain();

    // Mid-op reset in CAPTURE
    in_operand = 32'h55; in_type = SHIFT_SLL; in_use_reg_amt = 1'b0;
    in_shamt = 5'd1; in_rd = 5'd20; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("mrst_out_valid", DW'(out_valid), DW'(0));
    check("mrst_out_result", out_result, '0);
    check("mrst_out_rd", DW'(out_rd), DW'(0));
    check("mrst_in_ready", DW'(in_ready), DW'(0));
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("mrst_no_emit", DW'(out_valid), DW'(0));
    end

    // Normal operation after the mid-op reset
    send(32'h0000_1234, SHIFT_SLL, 1'b0, 5'd4, 32'd0, 5'd2, 32'h0001_2340, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
